packet_assembly_buffer: RTL
===========================

// Module: packet_assembly_buffer
// PURPOSE
//  Input-port stage of the NIC, directly upstream of the PACKET2MESSAGE message queue. Collects flits
//  arriving from the NoC router link into whole packets in two packet slots (double buffer). Presents
//  each completed packet as a flat vector and hands it over with the r_pkt_to_msg/g_pkt_to_msg handshake.
//  Returns one packet credit to the router per freed slot.
// PARAMETERS
//  FLIT_WIDTH          32  flit width; type field = flit[FLIT_WIDTH-1:FLIT_WIDTH-2]
//  MAX_PACKET_LENGHT   5   max flits per packet (head included)
//  N_BITS_FLIT_CNT     3   flit counter width, must hold MAX_PACKET_LENGHT
// PORTS
//  clk              in   1                              clock
//  rst              in   1                              synchronous active-high reset
//  flit_i           in   FLIT_WIDTH                     flit from router link
//  flit_valid_i     in   1                              flit_i valid this cycle (no stall possible)
//  credit_o         out  1                              1-cycle pulse: one packet slot freed
//  out_link_o       out  MAX_PACKET_LENGHT*FLIT_WIDTH   packet of read slot, flit k at [(k+1)*FW-1:k*FW]
//  r_pkt_to_msg_o   out  1                              request: read slot holds a complete packet
//  g_pkt_to_msg_i   in   1                              grant: consumer captures out_link_o this cycle
//  error_o          out  1                              sticky protocol-error flag
// BEHAVIOUR
//  - Flit types: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
//  - Slot state per slot: EMPTY -> FILLING -> FULL -> EMPTY. Write ptr wp, read ptr rp (1 bit each,
//    toggle on advance). Flit count cnt for the slot being filled.
//  - Reset: all slots EMPTY, slot data 0, wp=rp=0, cnt=0, credit_o=0, r_pkt_to_msg_o=0, error_o=0.
//  - Upstream starts with 2 packet credits; consumes one per HEAD/HEAD_TAIL sent.
//  - Accept (flit_valid_i=1), using state sampled at the clock edge:
//    HEAD, slot[wp] EMPTY: clear slot data, store at index 0, cnt=1, slot -> FILLING.
//    HEAD_TAIL, slot[wp] EMPTY: clear slot, store at index 0, slot -> FULL, wp advances.
//    BODY, slot[wp] FILLING, cnt<MAX: store at index cnt, cnt+1.
//    TAIL, slot[wp] FILLING, cnt<MAX: store at index cnt, slot -> FULL, wp advances.
//  - Errors (each sets error_o next cycle, cleared only by rst):
//    HEAD/HEAD_TAIL while slot[wp] FILLING: partial packet discarded, new head restarts the slot.
//    BODY/TAIL while slot[wp] not FILLING: flit dropped.
//    BODY with cnt==MAX: flit dropped, slot stays FILLING. TAIL with cnt==MAX: data dropped, slot -> FULL.
//    Any flit while slot[wp] FULL (credit violation): flit dropped, no state change.
//  - r_pkt_to_msg_o = (slot[rp]==FULL), combinational from registered state; out_link_o = slot[rp] data,
//    unused flit positions read 0. Both held stable until grant.
//  - Grant: g_pkt_to_msg_i=1 with r_pkt_to_msg_o=1 -> slot[rp] -> EMPTY, rp advances at that edge,
//    credit_o=1 on the next cycle only. Grant with r_pkt_to_msg_o=0 ignored (no error).
//  - Consumer's grant is a 1-cycle pulse, never on consecutive cycles; r may stay high back-to-back
//    when both slots are FULL.
//  - Simultaneous flit into slot[wp] and grant of slot[rp] (wp!=rp): both take effect.
//    Flit arriving the same cycle a grant frees slot[wp] sees FULL -> credit-violation drop.
//  - Latency: last flit at edge N -> r_pkt_to_msg_o high after edge N.
//  - rst mid-packet: partial packets and FULL slots are lost, no credit_o issued; router link
//    reset together with NIC.
// TESTING
//  - HEAD_TAIL 0xC0000010 -> next cycle r=1, out_link flit0=0xC0000010, others 0;
//    grant -> r=0, credit_o pulse 1 cycle later.
//  - HEAD,BODY,BODY,BODY,TAIL back-to-back -> r=1 after TAIL edge, 5 flits in order;
//    sixth BODY flit of a 6-flit packet -> dropped, error_o=1.
//  - Two HEAD_TAIL packets with no grant -> both slots FULL, r held; third flit dropped, error_o=1;
//    two grants (gap of 1 cycle) -> packets out in arrival order, two credit_o pulses.
//  - BODY without HEAD -> dropped, error_o=1, r=0, slot states unchanged.
//  - HEAD,BODY then new HEAD_TAIL -> partial discarded, r=1 with only HEAD_TAIL flit, error_o=1.
//  - rst asserted with one slot FULL and one FILLING -> next cycle r=0, error_o=0, credit_o=0,
//    out_link_o=0.

Source files
------------

// File: rtl/packet_assembly_buffer.sv
// Packet assembly buffer: collects router flits into two packet slots
// (double buffer). A completed packet is presented on out_link_o and handed
// over with the request/grant pair. Each slot freed by a grant returns one
// packet credit to the router.
//
// Handshake: r_pkt_to_msg_o is high while the read slot holds a complete
// packet; out_link_o is stable while it is high. A transfer happens on a
// clock edge where g_pkt_to_msg_i and r_pkt_to_msg_o are both high. A grant
// while r_pkt_to_msg_o is low is ignored.
module packet_assembly_buffer #(
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int N_BITS_FLIT_CNT   = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [FLIT_WIDTH-1:0]                   flit_i,
  input  logic                                    flit_valid_i,
  output logic                                    credit_o,
  output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o,
  output logic                                    r_pkt_to_msg_o,
  input  logic                                    g_pkt_to_msg_i,
  output logic                                    error_o
);

  localparam int PKT_W = MAX_PACKET_LENGHT * FLIT_WIDTH;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'b00,
    SLOT_FILLING = 2'b01,
    SLOT_FULL    = 2'b10
  } slot_state_t;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_t;

  slot_state_t                slot_state [2];
  logic [PKT_W-1:0]           slot_data  [2];
  logic                       wp;
  logic                       rp;
  logic [N_BITS_FLIT_CNT-1:0] cnt;

  flit_type_t       flit_type;
  logic             grant_ok;
  logic             cnt_full;
  logic [PKT_W-1:0] head_word;

  assign flit_type = flit_type_t'(flit_i[FLIT_WIDTH-1:FLIT_WIDTH-2]);
  assign grant_ok  = g_pkt_to_msg_i && r_pkt_to_msg_o;
  assign cnt_full  = (cnt == N_BITS_FLIT_CNT'(MAX_PACKET_LENGHT));
  // A new head always starts from a cleared slot so unused positions read 0.
  assign head_word = {{(PKT_W-FLIT_WIDTH){1'b0}}, flit_i};

  assign r_pkt_to_msg_o = (slot_state[rp] == SLOT_FULL);
  assign out_link_o     = slot_data[rp];

  // Slot state machines, pointers, flit counter, credit pulse and error flag.
  // When wp==rp and the slot is FULL, a flit is a credit violation and does
  // not touch slot state, so a same-cycle grant never conflicts with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        slot_state[s] <= SLOT_EMPTY;
        slot_data[s]  <= '0;
      end
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= '0;
      credit_o <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      credit_o <= grant_ok;
      if (grant_ok) begin
        slot_state[rp] <= SLOT_EMPTY;
        rp             <= ~rp;
      end
      if (flit_valid_i) begin
        if (slot_state[wp] == SLOT_FULL) begin
          error_o <= 1'b1;
        end else begin
          case (flit_type)
            FLIT_HEAD: begin
              if (slot_state[wp] == SLOT_FILLING) error_o <= 1'b1;
              slot_data[wp]  <= head_word;
              cnt            <= N_BITS_FLIT_CNT'(1);
              slot_state[wp] <= SLOT_FILLING;
            end
            FLIT_HEAD_TAIL: begin
              if (slot_state[wp] == SLOT_FILLING) error_o <= 1'b1;
              slot_data[wp]  <= head_word;
              slot_state[wp] <= SLOT_FULL;
              wp             <= ~wp;
            end
            FLIT_BODY: begin
              if (slot_state[wp] == SLOT_FILLING && !cnt_full) begin
                slot_data[wp][int'(cnt)*FLIT_WIDTH +: FLIT_WIDTH] <= flit_i;
                cnt <= cnt + N_BITS_FLIT_CNT'(1);
              end else begin
                error_o <= 1'b1;
              end
            end
            default: begin
              // TAIL: an over-long packet keeps its first flits and closes.
              if (slot_state[wp] == SLOT_FILLING) begin
                if (!cnt_full) begin
                  slot_data[wp][int'(cnt)*FLIT_WIDTH +: FLIT_WIDTH] <= flit_i;
                end else begin
                  error_o <= 1'b1;
                end
                slot_state[wp] <= SLOT_FULL;
                wp             <= ~wp;
              end else begin
                error_o <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
